// File: rtl/pulse_transmitter_symbol_sequencer.sv
// pulse_transmitter_symbol_sequencer
// Walks a small symbol memory ({level, prescaler, duration} words) and feeds
// each symbol to the downstream countdown timer. Params are presented one
// cycle before timer_en rises. The pin is held at the symbol level until the
// timer pulse arrives.
// Optional feature macro: PULSE_TRANSMITTER_LOOP_EN (repeat the program
// loop_count+1 times, adds loop_count / loop_remaining ports).
module pulse_transmitter_symbol_sequencer #(
   parameter int   DEPTH               = 8,
   parameter int   ADDR_WIDTH          = $clog2(DEPTH),
   parameter int   PRESCALER_SEL_WIDTH = 4,
   parameter int   TIMER_WIDTH         = 8,
   parameter logic IDLE_LEVEL          = 1'b0
) (
   input  logic                                      clk,
   input  logic                                      sys_rst,
   input  logic                                      wr_en,
   input  logic [ADDR_WIDTH-1:0]                     wr_addr,
   input  logic [PRESCALER_SEL_WIDTH+TIMER_WIDTH:0]  wr_data,
   input  logic [ADDR_WIDTH:0]                       prog_len,
   input  logic                                      start,
   input  logic                                      stop,
`ifdef PULSE_TRANSMITTER_LOOP_EN
   input  logic [7:0]                                loop_count,
   output logic [7:0]                                loop_remaining,
`endif
   output logic                                      busy,
   output logic                                      done,
   output logic                                      pin_out,
   output logic                                      timer_en,
   output logic [PRESCALER_SEL_WIDTH-1:0]            timer_prescaler,
   output logic [TIMER_WIDTH-1:0]                    timer_duration,
   input  logic                                      timer_pulse
);

   localparam int SYM_W = 1 + PRESCALER_SEL_WIDTH + TIMER_WIDTH;
   localparam int LEN_W = ADDR_WIDTH + 1;
   localparam logic [LEN_W-1:0] DEPTH_LEN = LEN_W'(DEPTH);

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_SETUP = 2'd1;
   localparam logic [1:0] ST_RUN   = 2'd2;
   localparam logic [1:0] ST_DONE  = 2'd3;

   logic [SYM_W-1:0]               mem_q [DEPTH];

   logic [1:0]                     state_q, state_d;
   logic [ADDR_WIDTH-1:0]          idx_q, idx_d;
   logic [ADDR_WIDTH-1:0]          last_q, last_d;
   logic                           busy_q, busy_d;
   logic                           done_q, done_d;
   logic                           ten_q, ten_d;
   logic                           pin_q, pin_d;
   logic [PRESCALER_SEL_WIDTH-1:0] pre_q, pre_d;
   logic [TIMER_WIDTH-1:0]         dur_q, dur_d;
`ifdef PULSE_TRANSMITTER_LOOP_EN
   logic [7:0]                     lrem_q, lrem_d;
`endif

   logic [ADDR_WIDTH-1:0]          ld_addr;
   logic [SYM_W-1:0]               ld_sym;
   logic [LEN_W-1:0]               len_clamp;
   logic                           at_last;
   logic                           wrap_ok;

   // Symbol memory: plain synchronous write, no reset, writable in any state.
   always_ff @(posedge clk) begin
      if (wr_en) begin
         mem_q[wr_addr] <= wr_data;
      end
   end

   // Address of the symbol that would be loaded at the next edge: the next
   // index while mid-program, otherwise entry 0 (start or loop wrap).
   always_comb begin
      ld_addr = '0;
      if (state_q == ST_RUN && idx_q != last_q) begin
         ld_addr = idx_q + ADDR_WIDTH'(1);
      end
   end

   assign ld_sym    = mem_q[ld_addr];
   assign len_clamp = (prog_len > DEPTH_LEN) ? DEPTH_LEN : prog_len;
   assign at_last   = (idx_q == last_q);

`ifdef PULSE_TRANSMITTER_LOOP_EN
   assign wrap_ok = (lrem_q != 8'd0);
`else
   assign wrap_ok = 1'b0;
`endif

   // Sequencer next-state and registered-output logic; stop has top priority.
   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      last_d  = last_q;
      busy_d  = busy_q;
      done_d  = 1'b0;
      ten_d   = ten_q;
      pin_d   = pin_q;
      pre_d   = pre_q;
      dur_d   = dur_q;
`ifdef PULSE_TRANSMITTER_LOOP_EN
      lrem_d  = lrem_q;
`endif
      if (stop) begin
         state_d = ST_IDLE;
         idx_d   = '0;
         busy_d  = 1'b0;
         ten_d   = 1'b0;
         pin_d   = IDLE_LEVEL;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (start) begin
`ifdef PULSE_TRANSMITTER_LOOP_EN
                  lrem_d = loop_count;
`endif
                  if (prog_len != '0) begin
                     state_d = ST_SETUP;
                     idx_d   = '0;
                     // len_clamp >= 1 here, so len-1 fits the index width
                     last_d  = ADDR_WIDTH'(len_clamp - LEN_W'(1));
                     busy_d  = 1'b1;
                     pin_d   = ld_sym[SYM_W-1];
                     pre_d   = ld_sym[PRESCALER_SEL_WIDTH+TIMER_WIDTH-1:TIMER_WIDTH];
                     dur_d   = ld_sym[TIMER_WIDTH-1:0];
                  end else begin
                     state_d = ST_DONE;
                     done_d  = 1'b1;
                  end
               end
            end
            ST_SETUP: begin
               state_d = ST_RUN;
               ten_d   = 1'b1;
            end
            ST_RUN: begin
               if (timer_pulse) begin
                  ten_d = 1'b0;
                  if (at_last && !wrap_ok) begin
                     state_d = ST_DONE;
                     idx_d   = '0;
                     done_d  = 1'b1;
                     busy_d  = 1'b0;
                     pin_d   = IDLE_LEVEL;
                  end else begin
                     state_d = ST_SETUP;
                     idx_d   = ld_addr;
                     pin_d   = ld_sym[SYM_W-1];
                     pre_d   = ld_sym[PRESCALER_SEL_WIDTH+TIMER_WIDTH-1:TIMER_WIDTH];
                     dur_d   = ld_sym[TIMER_WIDTH-1:0];
`ifdef PULSE_TRANSMITTER_LOOP_EN
                     if (at_last) begin
                        lrem_d = lrem_q - 8'd1;
                     end
`endif
                  end
               end
            end
            ST_DONE: begin
               state_d = ST_IDLE;
               idx_d   = '0;
            end
            default: begin
               state_d = ST_IDLE;
               idx_d   = '0;
               busy_d  = 1'b0;
               ten_d   = 1'b0;
               pin_d   = IDLE_LEVEL;
            end
         endcase
      end
   end

   // State and output registers with asynchronous reset.
   always_ff @(posedge clk or posedge sys_rst) begin
      if (sys_rst) begin
         state_q <= ST_IDLE;
         idx_q   <= '0;
         last_q  <= '0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         ten_q   <= 1'b0;
         pin_q   <= IDLE_LEVEL;
         pre_q   <= '0;
         dur_q   <= '0;
`ifdef PULSE_TRANSMITTER_LOOP_EN
         lrem_q  <= '0;
`endif
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         last_q  <= last_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
         ten_q   <= ten_d;
         pin_q   <= pin_d;
         pre_q   <= pre_d;
         dur_q   <= dur_d;
`ifdef PULSE_TRANSMITTER_LOOP_EN
         lrem_q  <= lrem_d;
`endif
      end
   end

   assign busy            = busy_q;
   assign done            = done_q;
   assign pin_out         = pin_q;
   assign timer_en        = ten_q;
   assign timer_prescaler = pre_q;
   assign timer_duration  = dur_q;
`ifdef PULSE_TRANSMITTER_LOOP_EN
   assign loop_remaining  = lrem_q;
`endif

endmodule

// File: tb/tb_pulse_transmitter_symbol_sequencer.sv
// Testbench for pulse_transmitter_symbol_sequencer. Acts as the countdown
// timer (pulse after dur[1:0]+1 cycles of en) and checks the symbol stream
// against a shadow copy of the symbol memory.
module tb_pulse_transmitter_symbol_sequencer;

   localparam int   DEPTH = 8;
   localparam int   AW    = 3;
   localparam int   LW    = AW + 1;
   localparam int   PW    = 4;
   localparam int   TW    = 8;
   localparam int   SW    = 1 + PW + TW;
   localparam logic IDLE  = 1'b0;

   logic          clk = 1'b0;
   logic          sys_rst;
   logic          wr_en;
   logic [AW-1:0] wr_addr;
   logic [SW-1:0] wr_data;
   logic [LW-1:0] prog_len;
   logic          start;
   logic          stop;
   logic          busy;
   logic          done;
   logic          pin_out;
   logic          timer_en;
   logic [PW-1:0] timer_prescaler;
   logic [TW-1:0] timer_duration;
   logic          timer_pulse;
`ifdef PULSE_TRANSMITTER_LOOP_EN
   logic [7:0]    loop_count;
   logic [7:0]    loop_remaining;
`endif

   logic [SW-1:0] shadow [DEPTH];
   int            n_chk  = 0;
   int            n_fail = 0;

   pulse_transmitter_symbol_sequencer #(
      .DEPTH(DEPTH),
      .ADDR_WIDTH(AW),
      .PRESCALER_SEL_WIDTH(PW),
      .TIMER_WIDTH(TW),
      .IDLE_LEVEL(IDLE)
   ) dut (
      .clk(clk),
      .sys_rst(sys_rst),
      .wr_en(wr_en),
      .wr_addr(wr_addr),
      .wr_data(wr_data),
      .prog_len(prog_len),
      .start(start),
      .stop(stop),
`ifdef PULSE_TRANSMITTER_LOOP_EN
      .loop_count(loop_count),
      .loop_remaining(loop_remaining),
`endif
      .busy(busy),
      .done(done),
      .pin_out(pin_out),
      .timer_en(timer_en),
      .timer_prescaler(timer_prescaler),
      .timer_duration(timer_duration),
      .timer_pulse(timer_pulse)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic chk_io(input string tag, input logic e_en, input logic e_busy,
                         input logic e_pin, input logic e_done);
      chk({tag, "_en"},   32'(timer_en), 32'(e_en));
      chk({tag, "_busy"}, 32'(busy),     32'(e_busy));
      chk({tag, "_pin"},  32'(pin_out),  32'(e_pin));
      chk({tag, "_done"}, 32'(done),     32'(e_done));
   endtask

   task automatic chk_par(input string tag, input logic [SW-1:0] s);
      chk({tag, "_pre"}, 32'(timer_prescaler), 32'(s[PW+TW-1:TW]));
      chk({tag, "_dur"}, 32'(timer_duration),  32'(s[TW-1:0]));
   endtask

   task automatic write_sym(input logic [AW-1:0] a, input logic [SW-1:0] d);
      wr_en   = 1'b1;
      wr_addr = a;
      wr_data = d;
      shadow[a] = d;
      @(negedge clk);
      wr_en = 1'b0;
   endtask

   // Start a program and follow it symbol by symbol. abort_at >= 0 issues
   // stop in the first RUN cycle of that symbol (optionally with start).
   task automatic run_prog(input int len_req, input int loops, input int abort_at,
                           input bit abort_start, input bit mid_write);
      int n, total, lat;
      logic [SW-1:0] s;
      n     = (len_req > DEPTH) ? DEPTH : len_req;
      total = n * (loops + 1);
      prog_len = LW'(len_req);
`ifdef PULSE_TRANSMITTER_LOOP_EN
      loop_count = 8'(loops);
`endif
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      for (int k = 0; k < total; k++) begin
         s = shadow[k % n];
         chk_io("setup", 1'b0, 1'b1, s[SW-1], 1'b0);
         chk_par("setup", s);
`ifdef PULSE_TRANSMITTER_LOOP_EN
         chk("setup_loop_rem", 32'(loop_remaining), 32'(loops - k / n));
`endif
         @(negedge clk);
         lat = int'(s[1:0]) + 1;
         for (int c = 1; c <= lat; c++) begin
            chk_io("run", 1'b1, 1'b1, s[SW-1], 1'b0);
            chk_par("run", s);
            if (c == 1 && k == abort_at) begin
               stop  = 1'b1;
               start = abort_start;
               @(negedge clk);
               stop  = 1'b0;
               start = 1'b0;
               chk_io("abort", 1'b0, 1'b0, IDLE, 1'b0);
               @(negedge clk);
               chk_io("abort_hold", 1'b0, 1'b0, IDLE, 1'b0);
               return;
            end
            if (c == 1 && k == 0 && mid_write && n >= 3) begin
               wr_en   = 1'b1;
               wr_addr = AW'(n - 1);
               wr_data = SW'($urandom);
               shadow[n - 1] = wr_data;
            end
            if (c == lat) timer_pulse = 1'b1;
            @(negedge clk);
            wr_en       = 1'b0;
            timer_pulse = 1'b0;
         end
      end
      chk_io("done", 1'b0, 1'b0, IDLE, 1'b1);
`ifdef PULSE_TRANSMITTER_LOOP_EN
      chk("done_loop_rem", 32'(loop_remaining), 32'(0));
`endif
      @(negedge clk);
      chk_io("after_done", 1'b0, 1'b0, IDLE, 1'b0);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      sys_rst     = 1'b1;
      start       = 1'b0;
      stop        = 1'b0;
      wr_en       = 1'b0;
      wr_addr     = '0;
      wr_data     = '0;
      prog_len    = '0;
      timer_pulse = 1'b0;
`ifdef PULSE_TRANSMITTER_LOOP_EN
      loop_count  = '0;
`endif
      repeat (3) @(negedge clk);
      chk_io("reset", 1'b0, 1'b0, IDLE, 1'b0);
      chk("reset_pre", 32'(timer_prescaler), 32'(0));
      chk("reset_dur", 32'(timer_duration), 32'(0));
      sys_rst = 1'b0;
      @(negedge clk);

      // Directed three-symbol program
      write_sym(3'd0, {1'b1, 4'd0, 8'd5});
      write_sym(3'd1, {1'b0, 4'd1, 8'd3});
      write_sym(3'd2, {1'b1, 4'd2, 8'd7});
      run_prog(3, 0, -1, 1'b0, 1'b0);

      // Empty program: done on the next cycle, nothing transmitted
      prog_len = '0;
      start    = 1'b1;
      @(negedge clk);
      start = 1'b0;
      chk_io("len0", 1'b0, 1'b0, IDLE, 1'b1);
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk_io("len0_after", 1'b0, 1'b0, IDLE, 1'b0);
      end

      // Stray timer pulse while idle
      timer_pulse = 1'b1;
      @(negedge clk);
      timer_pulse = 1'b0;
      chk_io("stray", 1'b0, 1'b0, IDLE, 1'b0);
      @(negedge clk);
      chk_io("stray_hold", 1'b0, 1'b0, IDLE, 1'b0);

      // Abort in the second symbol, alone and together with start
      run_prog(3, 0, 1, 1'b0, 1'b0);
      run_prog(3, 0, 1, 1'b1, 1'b0);
      run_prog(3, 0, -1, 1'b0, 1'b0);

      // Asynchronous reset in the middle of RUN
      prog_len = LW'(3);
      start    = 1'b1;
      @(negedge clk);
      start = 1'b0;
      @(negedge clk);
      #2 sys_rst = 1'b1;
      #1 chk_io("rst_mid", 1'b0, 1'b0, IDLE, 1'b0);
      @(negedge clk);
      sys_rst = 1'b0;
      @(negedge clk);
      run_prog(3, 0, -1, 1'b0, 1'b0);

`ifdef PULSE_TRANSMITTER_LOOP_EN
      // Two symbols, three passes
      run_prog(2, 2, -1, 1'b0, 1'b0);
      timer_pulse = 1'b1;
      @(negedge clk);
      timer_pulse = 1'b0;
      chk_io("loop_stray", 1'b0, 1'b0, IDLE, 1'b0);
`endif

      // Randomized programs, including lengths above DEPTH and mid-run writes
      for (int it = 0; it < 10; it++) begin
         int len, loops;
         for (int i = 0; i < DEPTH; i++) begin
            write_sym(AW'(i), SW'($urandom));
         end
         len   = int'($urandom_range(1, DEPTH + 3));
         loops = 0;
`ifdef PULSE_TRANSMITTER_LOOP_EN
         loops = int'($urandom_range(0, 2));
`endif
         run_prog(len, loops, -1, 1'b0, (it % 2) == 1);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/pulse_transmitter_symbol_sequencer.md
Name: pulse_transmitter_symbol_sequencer

Overview:
Upstream sequencer that drives the pulse transmitter's repeating countdown timer and owns the output pin. It holds a small symbol memory. Each symbol word is {level, prescaler, duration}. The sequencer presents each symbol's prescaler and duration to the timer one cycle before enabling it. It drives the pin to the symbol's level until the timer's 1-cycle pulse, then advances to the next symbol.

Parameters:
DEPTH, 8, number of symbol entries (power of two, >= 2)
ADDR_WIDTH, $clog2(DEPTH), symbol index width
PRESCALER_SEL_WIDTH, 4, width of prescaler field (matches timer prescaler port)
TIMER_WIDTH, 8, width of duration field (matches timer duration port)
IDLE_LEVEL, 1'b0, pin level when not transmitting

Ports:
clk  in  1  system clock
sys_rst  in  1  asynchronous active-high reset
wr_en  in  1  write symbol memory this cycle
wr_addr  in  ADDR_WIDTH  symbol write index
wr_data  in  1+PRESCALER_SEL_WIDTH+TIMER_WIDTH  {level, prescaler, duration}, level is MSB
prog_len  in  ADDR_WIDTH+1  number of symbols to send (0..DEPTH)
start  in  1  1-cycle start request
stop  in  1  1-cycle abort request
busy  out  1  high from start acceptance until DONE/abort
done  out  1  1-cycle pulse on normal completion
pin_out  out  1  transmitted level
timer_en  out  1  to countdown timer en
timer_prescaler  out  PRESCALER_SEL_WIDTH  to timer prescaler
timer_duration  out  TIMER_WIDTH  to timer duration
timer_pulse  in  1  timer pulse_out (symbol period elapsed)

Behaviour:
- One clock; reset is asynchronous and active-high (sys_rst).
- Reset values:
  - state = IDLE, idx = 0, busy = 0, done = 0, timer_en = 0.
  - timer_prescaler = 0, timer_duration = 0, pin_out = IDLE_LEVEL.
  - Symbol memory is not reset.
- All outputs are registered.
- Memory: synchronous write on wr_en. Writes are allowed in any state. A symbol is sampled when it is loaded, so a write to a not-yet-loaded index while busy takes effect.
- IDLE:
  - start with prog_len != 0: load mem[0] into timer_prescaler, timer_duration and pin_out(level). Set idx = 0, busy = 1 and go to SETUP.
  - start with prog_len == 0: go to DONE. pin_out stays IDLE_LEVEL and no symbols are sent.
  - timer_pulse is ignored.
- SETUP (exactly 1 cycle): timer_en = 0, params stable. Next edge: timer_en <= 1, go to RUN.
- RUN: timer_en = 1, hold params and pin_out until timer_pulse = 1. On timer_pulse:
  - If idx == prog_len-1: go to DONE.
  - Otherwise: idx <= idx+1, load mem[idx+1] params and level in the same edge, timer_en <= 0, go to SETUP.
- Between symbols timer_en is therefore low for exactly one cycle. This guarantees the timer sees new params one cycle before en.
- DONE (1 cycle): done = 1, busy = 0, timer_en = 0, pin_out = IDLE_LEVEL. Next state is IDLE.
- Entering DONE from RUN sets pin_out <= IDLE_LEVEL on the same edge as the final timer_pulse is consumed.
- stop:
  - In any state, at the next edge: IDLE, timer_en = 0, busy = 0, pin_out = IDLE_LEVEL.
  - No done pulse.
  - stop and start in the same cycle: stop wins.
- start while busy: ignored.
- prog_len > DEPTH: clamp to DEPTH.
- prog_len is sampled at start and held internally for the whole run.
- idx arithmetic is ADDR_WIDTH wide; the last-symbol compare uses the latched length.
- Pin level change latency: pin_out changes on the same edge that consumes timer_pulse.
- Per-symbol pin time = 1 SETUP cycle + timer first-pulse latency after en rises.

Optional Feature:
Macro: PULSE_TRANSMITTER_LOOP_EN.
- Defined:
  - Adds input loop_count[7:0], sampled at start. The program repeats loop_count+1 times.
  - At the last symbol with loops remaining, idx wraps to 0 and goes to SETUP (no DONE, pin loads mem[0].level).
  - done pulses only after the final pass. stop aborts immediately.
  - Adds output loop_remaining[7:0]: reset 0, equals loop_count at start, decrements on each wrap.
- Undefined: ports are absent; single pass only.

Test Plan:
- Reset mid-RUN (assert sys_rst async, between edges) -> pin_out = IDLE_LEVEL, timer_en = 0, busy = 0 immediately; start after release works normally.
- Write 3 symbols {1,0,5},{0,1,3},{1,2,7}, prog_len = 3, start; bench timer model -> first timer_en rise 2 cycles after start; timer_prescaler/duration are stable the cycle before each timer_en rise. pin_out follows 1,0,1 then IDLE_LEVEL, with one done pulse and busy low after it.
- Between symbols -> timer_en low exactly 1 cycle after each timer_pulse, except after the last.
- prog_len = 0, start -> done pulses at cycle +1, timer_en never rises, pin_out constant IDLE_LEVEL.
- stop asserted during the 2nd symbol's RUN (with start in same cycle in a second run) -> next edge IDLE, pin_out = IDLE_LEVEL, no done; stop+start together -> stays IDLE.
- PULSE_TRANSMITTER_LOOP_EN, prog_len = 2, loop_count = 2 -> 6 symbols sent, loop_remaining goes 2,1,0, single done at end; stray timer_pulse in IDLE ignored.
